// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - leaky integrate-and-fire neuron with refractory period
module lif_neuron_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_wspike,
  input  logic       i_svalid,
  input  logic [3:0] i_State,
  input  logic       i_recc,
  input  logic [5:0] i_Thres,
  input  logic       i_Thres_valid,
  output logic [5:0] o_V,
  output logic       o_spike
);

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic  [5:0] r_v;
  logic  [5:0] w_v_nxt;
  logic        r_spike;
  logic        w_spike_nxt;
  logic  [1:0] r_cnt;
  logic  [1:0] w_cnt_nxt;

  logic  [5:0] r_thr;
  logic  [1:0] r_leak;
  logic  [1:0] r_rfr;
  logic        r_mode;

  logic  [2:0] w_add;
  logic signed [7:0] w_sum;
  logic  [5:0] w_sat;
  logic        w_fire;
  logic  [5:0] w_residue;

  // Configuration registers; a zero threshold is promoted to 1 so an idle
  // neuron at V=0 can never fire on its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_thr  <= 6'd32;
      r_leak <= 2'd1;
      r_rfr  <= 2'd0;
      r_mode <= 1'b0;
    end else if (i_Thres_valid) begin
      r_thr  <= (i_Thres == 6'd0) ? 6'd1 : i_Thres;
      r_leak <= i_State[1:0];
      r_rfr  <= i_State[3:2];
      r_mode <= i_recc;
    end
  end

  // Integration datapath: signed sum so leak below zero is visible, then clamp to 0..63.
  always_comb begin
    w_add     = i_svalid ? i_wspike : 3'd0;
    w_sum     = $signed({2'b00, r_v}) + $signed({5'b00000, w_add})
              - $signed({6'b000000, r_leak});
    if (w_sum < 8'sd0) begin
      w_sat = 6'd0;
    end else if (w_sum > 8'sd63) begin
      w_sat = 6'd63;
    end else begin
      w_sat = w_sum[5:0];
    end
    w_fire    = (w_sat >= r_thr);
    w_residue = w_sat - r_thr;
  end

  // Next-state and next-output logic for the INTEG/REFRAC controller.
  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_spike_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INTEG: begin
        if (w_fire) begin
          w_spike_nxt = 1'b1;
          w_v_nxt     = r_mode ? w_residue : 6'd0;
          if (r_rfr != 2'd0) begin
            w_state_nxt = REFRAC;
            w_cnt_nxt   = r_rfr;
          end else begin
            w_cnt_nxt   = 2'd0;
          end
        end else begin
          w_v_nxt = w_sat;
        end
      end
      REFRAC: begin
        // Inputs are dropped and V held; leave once the last dropped cycle is counted.
        if (r_cnt <= 2'd1) begin
          w_state_nxt = INTEG;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = INTEG;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // State, membrane potential and spike registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INTEG;
      r_v     <= 6'd0;
      r_spike <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_spike <= w_spike_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_V     = r_v;
  assign o_spike = r_spike;

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb/tb_lif_neuron_core.sv - scoreboard bench for lif_neuron_core
module tb_lif_neuron_core;

  logic       clk;
  logic       rst_n;
  logic [2:0] i_wspike;
  logic       i_svalid;
  logic [3:0] i_State;
  logic       i_recc;
  logic [5:0] i_Thres;
  logic       i_Thres_valid;
  logic [5:0] o_V;
  logic       o_spike;

  typedef struct {
    logic [5:0] v;
    logic       s;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  bit   done;

  lif_neuron_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wspike      (i_wspike),
    .i_svalid      (i_svalid),
    .i_State       (i_State),
    .i_recc        (i_recc),
    .i_Thres       (i_Thres),
    .i_Thres_valid (i_Thres_valid),
    .o_V           (o_V),
    .o_spike       (o_spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic sv, input logic [2:0] w,
                      input logic tv, input logic [5:0] th, input logic [3:0] st,
                      input logic rc, input logic [5:0] ev, input logic es,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst_n         = rn;
    i_svalid      = sv;
    i_wspike      = w;
    i_Thres_valid = tv;
    i_Thres       = th;
    i_State       = st;
    i_recc        = rc;
    e.v  = ev;
    e.s  = es;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drv(input logic sv, input logic [2:0] w, input logic [5:0] ev,
                     input logic es, input string nm);
    step(1'b1, sv, w, 1'b0, 6'd0, 4'd0, 1'b0, ev, es, nm);
  endtask

  task automatic load(input logic [5:0] th, input logic [3:0] st, input logic rc,
                      input logic sv, input logic [2:0] w, input logic [5:0] ev,
                      input logic es, input string nm);
    step(1'b1, sv, w, 1'b1, th, st, rc, ev, es, nm);
  endtask

  // Monitor: one output per clock; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (o_V !== e.v || o_spike !== e.s) begin
          failures++;
          $display("FAIL %s: o_V=%0d o_spike=%0d, expected o_V=%0d o_spike=%0d",
                   e.nm, o_V, o_spike, e.v, e.s);
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    done = 1'b0;
    rst_n = 1'b0; i_svalid = 1'b0; i_wspike = 3'd0; i_Thres_valid = 1'b0;
    i_Thres = 6'd0; i_State = 4'd0; i_recc = 1'b0;

    // reset and idle (leak floors at 0)
    step(1'b0, 1'b0, 3'd0, 1'b1, 6'd5, 4'hF, 1'b1, 6'd0, 1'b0, "rst0");
    step(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 4'd0, 1'b0, 6'd0, 1'b0, "rst1");
    drv(1'b0, 3'd0, 6'd0, 1'b0, "idle0");
    drv(1'b0, 3'd0, 6'd0, 1'b0, "idle1");

    // reset-to-zero
    load(6'd10, 4'b0000, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, "r2z_load");
    drv(1'b1, 3'd3, 6'd3, 1'b0, "r2z_1");
    drv(1'b1, 3'd3, 6'd6, 1'b0, "r2z_2");
    drv(1'b1, 3'd3, 6'd9, 1'b0, "r2z_3");
    drv(1'b1, 3'd3, 6'd0, 1'b1, "r2z_fire");
    drv(1'b0, 3'd0, 6'd0, 1'b0, "r2z_after");

    // reset-by-subtraction
    load(6'd10, 4'b0000, 1'b1, 1'b0, 3'd0, 6'd0, 1'b0, "rbs_load");
    drv(1'b1, 3'd3, 6'd3, 1'b0, "rbs_1");
    drv(1'b1, 3'd3, 6'd6, 1'b0, "rbs_2");
    drv(1'b1, 3'd3, 6'd9, 1'b0, "rbs_3");
    drv(1'b1, 3'd3, 6'd2, 1'b1, "rbs_fire");
    drv(1'b0, 3'd0, 6'd2, 1'b0, "rbs_hold");

    // leak=2 from V=1 clamps to 0
    load(6'd10, 4'b0010, 1'b0, 1'b0, 3'd0, 6'd2, 1'b0, "leak_load");
    drv(1'b1, 3'd1, 6'd1, 1'b0, "leak_v1");
    drv(1'b0, 3'd0, 6'd0, 1'b0, "leak_clamp");

    // saturation at 63 fires with thr=63
    load(6'd63, 4'b0000, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, "sat_load");
    for (int i = 1; i <= 8; i++) drv(1'b1, 3'd7, 6'(7 * i), 1'b0, "sat_ramp");
    drv(1'b1, 3'd2, 6'd58, 1'b0, "sat_58");
    drv(1'b1, 3'd7, 6'd0, 1'b1, "sat_fire");

    // refractory rfr=2, subtraction mode so the held V is non-zero
    load(6'd4, 4'b1000, 1'b1, 1'b0, 3'd0, 6'd0, 1'b0, "rfr_load");
    drv(1'b1, 3'd7, 6'd3, 1'b1, "rfr_fire1");
    drv(1'b1, 3'd7, 6'd3, 1'b0, "rfr_drop1");
    drv(1'b1, 3'd7, 6'd3, 1'b0, "rfr_drop2");
    drv(1'b1, 3'd7, 6'd6, 1'b1, "rfr_fire2");
    drv(1'b1, 3'd7, 6'd6, 1'b0, "rfr_drop3");

    // reset during refractory restores INTEG and default config
    step(1'b0, 1'b1, 3'd7, 1'b0, 6'd0, 4'd0, 1'b0, 6'd0, 1'b0, "rst_in_rfr");
    for (int i = 1; i <= 5; i++) drv(1'b1, 3'd7, 6'(6 * i), 1'b0, "dflt_ramp");
    drv(1'b1, 3'd7, 6'd0, 1'b1, "dflt_fire");
    drv(1'b1, 3'd7, 6'd6, 1'b0, "dflt_norfr");

    // thr=0 stored as 1; back-to-back spikes with rfr=0
    load(6'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 6'd5, 1'b0, "thr0_load");
    drv(1'b1, 3'd1, 6'd0, 1'b1, "thr1_fire");
    drv(1'b1, 3'd1, 6'd0, 1'b1, "b2b_fire");
    drv(1'b0, 3'd0, 6'd0, 1'b0, "thr1_idle");

    // same-cycle config load uses the old threshold
    load(6'd20, 4'b0000, 1'b0, 1'b1, 3'd1, 6'd0, 1'b1, "old_thr");
    drv(1'b1, 3'd7, 6'd7, 1'b0, "new_thr1");
    drv(1'b1, 3'd7, 6'd14, 1'b0, "new_thr2");
    drv(1'b1, 3'd7, 6'd0, 1'b1, "new_thr_fire");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
